// File: rtl/seg_sched_if.sv
// seg_sched_if: bundle between the display requesters and the seg_sched
// time-slicing scheduler.
//   req_valid   [NUM_REQ]     requester wants the display (level-held)
//   req_value   [16*NUM_REQ]  requester i value in bits [16*i+15:16*i]
//   req_blink   [NUM_REQ]     blink request per requester (SEG_SCHED_BLINK_EN only)
//   grant       [NUM_REQ]     one-hot current owner, zero when idle
//   grant_pulse [NUM_REQ]     one-cycle pulse when ownership is taken
//   disp_value  [16]          registered value for the display
//   blank                     display must show nothing
//   scan_tick                 one-cycle digit-advance enable
// Modports: master = requester side, slave = scheduler side.
// Optional macro: SEG_SCHED_BLINK_EN adds req_blink.
interface seg_sched_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_value;
`ifdef SEG_SCHED_BLINK_EN
  logic [NUM_REQ-1:0]    req_blink;
`endif
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    grant_pulse;
  logic [15:0]           disp_value;
  logic                  blank;
  logic                  scan_tick;

  modport master (
    output req_valid, req_value,
`ifdef SEG_SCHED_BLINK_EN
    output req_blink,
`endif
    input  grant, grant_pulse, disp_value, blank, scan_tick
  );

  modport slave (
    input  req_valid, req_value,
`ifdef SEG_SCHED_BLINK_EN
    input  req_blink,
`endif
    output grant, grant_pulse, disp_value, blank, scan_tick
  );
endinterface

// File: rtl/seg_sched.sv
// seg_sched: shares one 4-digit 7-segment display between NUM_REQ
// requesters. Round-robin ownership with a minimum hold time, optional
// preemption by requester 0 (PRIO0), and a free-running scan divider
// producing scan_tick every SCAN_DIV cycles.
// Ports:
//   clk_in  - single clock
//   rst_in  - synchronous active-high reset
//   bus     - seg_sched_if.slave (requests in; grant/display/scan out)
// Optional macro: SEG_SCHED_BLINK_EN adds per-requester blinking of the
// display (parameter BLINK_DIV, counted in scan_tick pulses).
module seg_sched #(
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int SCAN_DIV    = 16,
  parameter int PRIO0       = 1
`ifdef SEG_SCHED_BLINK_EN
  , parameter int BLINK_DIV = 64
`endif
) (
  input logic        clk_in,
  input logic        rst_in,
  seg_sched_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [PW-1:0]      owner_reg, owner_next;
  logic [PW-1:0]      rr_reg, rr_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] pulse_reg, pulse_next;
  logic [HW-1:0]      hold_reg, hold_next;
  logic [SW-1:0]      scan_reg;
  logic [15:0]        disp_reg, disp_next;
  logic               blank_reg, blank_next;
  logic [15:0]        req_word [NUM_REQ];
  logic [NUM_REQ-1:0] others;
  logic               take;
  logic [PW-1:0]      sel;
  logic [PW:0]        pick_res;
  logic               scan_tick;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
    assign req_word[gi] = bus.req_value[16*gi +: 16];
  end

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == LAST_REQ) ? '0 : i + 1'b1;
  endfunction

  // Returns {found, index}: first set bit at or after ptr, wrapping.
  // With PRIO0 set, index 0 wins whenever it is present in v.
  function automatic logic [PW:0] pick(input logic [NUM_REQ-1:0] v,
                                       input logic [PW-1:0]      ptr);
    logic          found;
    logic [PW-1:0] idx;
    logic [PW-1:0] j;
    found = 1'b0;
    idx   = '0;
    j     = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && v[j]) begin
        found = 1'b1;
        idx   = j;
      end
      j = next_idx(j);
    end
    if (PRIO0 != 0 && v[0]) begin
      found = 1'b1;
      idx   = '0;
    end
    return {found, idx};
  endfunction

  assign scan_tick = (scan_reg == SCAN_MAX);

`ifdef SEG_SCHED_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_phase_reg;

  // Phase 1 = blanked half of the blink period; restarts visible on
  // every ownership change and whenever the owner is not blinking.
  always_ff @(posedge clk_in) begin
    if (rst_in || take || state_reg != HOLD || !bus.req_blink[owner_reg]) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (scan_tick) begin
      if (blink_cnt_reg == BLINK_MAX) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    rr_next    = rr_reg;
    grant_next = grant_reg;
    pulse_next = '0;
    hold_next  = hold_reg;
    disp_next  = disp_reg;
    take       = 1'b0;
    sel        = '0;
    pick_res   = '0;
    others     = bus.req_valid;
    others[owner_reg] = 1'b0;

    case (state_reg)
      IDLE: begin
        pick_res = pick(bus.req_valid, rr_reg);
        take     = pick_res[PW];
        sel      = pick_res[PW-1:0];
      end
      HOLD: begin
        disp_next = req_word[owner_reg];
        if (hold_reg != HOLD_MAX) hold_next = hold_reg + 1'b1;
        // Owner drop outranks expiry; preemption outranks expiry.
        if (!bus.req_valid[owner_reg]) begin
          pick_res = pick(others, rr_reg);
          take     = pick_res[PW];
          sel      = pick_res[PW-1:0];
          if (!pick_res[PW]) begin
            state_next = IDLE;
            grant_next = '0;
          end
        end else if (PRIO0 != 0 && owner_reg != '0 && bus.req_valid[0]) begin
          take = 1'b1;
          sel  = '0;
        end else if (hold_reg == HOLD_MAX && (|others) &&
                     !(PRIO0 != 0 && owner_reg == '0)) begin
          rr_next  = next_idx(owner_reg);
          pick_res = pick(others, next_idx(owner_reg));
          take     = 1'b1;
          sel      = pick_res[PW-1:0];
        end
      end
      default: state_next = IDLE;
    endcase

    if (take) begin
      state_next      = HOLD;
      owner_next      = sel;
      grant_next      = '0;
      grant_next[sel] = 1'b1;
      pulse_next      = grant_next;
      hold_next       = '0;
    end

`ifdef SEG_SCHED_BLINK_EN
    blank_next = (state_reg == IDLE) || (bus.req_blink[owner_reg] && blink_phase_reg);
`else
    blank_next = (state_reg == IDLE);
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      rr_reg    <= '0;
      grant_reg <= '0;
      pulse_reg <= '0;
      hold_reg  <= '0;
      scan_reg  <= '0;
      disp_reg  <= 16'h0000;
      blank_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      rr_reg    <= rr_next;
      grant_reg <= grant_next;
      pulse_reg <= pulse_next;
      hold_reg  <= hold_next;
      scan_reg  <= (scan_reg == SCAN_MAX) ? '0 : scan_reg + 1'b1;
      disp_reg  <= disp_next;
      blank_reg <= blank_next;
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.grant_pulse = pulse_reg;
  assign bus.disp_value  = disp_reg;
  assign bus.blank       = blank_reg;
  assign bus.scan_tick   = scan_tick;
endmodule

// File: tb/tb_seg_sched.sv
// tb_seg_sched: directed bench for seg_sched. dut_a runs pure round-robin
// (PRIO0=0), dut_b runs with requester-0 preemption (PRIO0=1); both use
// NUM_REQ=2, HOLD_CYCLES=8, SCAN_DIV=4. Inputs change 1 ns after a rising
// edge and outputs are sampled at that same point.
module tb_seg_sched;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   n_vec  = 0;
  int   n_err  = 0;

  always #5 clk_in = ~clk_in;

  seg_sched_if #(.NUM_REQ(2)) if_a ();
  seg_sched_if #(.NUM_REQ(2)) if_b ();

  seg_sched #(.NUM_REQ(2), .HOLD_CYCLES(8), .SCAN_DIV(4), .PRIO0(0)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .bus(if_a));
  seg_sched #(.NUM_REQ(2), .HOLD_CYCLES(8), .SCAN_DIV(4), .PRIO0(1)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .bus(if_b));

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    if_a.req_valid = '0;
    if_a.req_value = '0;
    if_b.req_valid = '0;
    if_b.req_value = '0;
`ifdef SEG_SCHED_BLINK_EN
    if_a.req_blink = '0;
    if_b.req_blink = '0;
`endif
    // Reset, then 20 idle cycles; cycle 1 is the one after the last reset edge.
    repeat (3) cyc();
    rst_in = 1'b0;
    chk("rst_blank", 16'(if_a.blank), 16'h1);
    chk("rst_grant", 16'(if_a.grant), 16'h0);
    chk("rst_pulse", 16'(if_a.grant_pulse), 16'h0);
    chk("rst_disp", if_a.disp_value, 16'h0000);
    chk("rst_grant_b", 16'(if_b.grant), 16'h0);
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) cyc();
      chk($sformatf("scan_k%0d", k), 16'(if_a.scan_tick), (k % 4 == 0) ? 16'h1 : 16'h0);
    end
    chk("idle_blank", 16'(if_a.blank), 16'h1);
    chk("idle_grant", 16'(if_a.grant), 16'h0);
    chk("idle_disp", if_a.disp_value, 16'h0000);

    // Single requester 1, live value tracking.
    if_a.req_valid = 2'b10;
    if_a.req_value = {16'hABCD, 16'h5555};
    cyc();
    chk("take_pulse", 16'(if_a.grant_pulse), 16'h2);
    chk("take_grant", 16'(if_a.grant), 16'h2);
    chk("take_disp_lag", if_a.disp_value, 16'h0000);
    chk("take_blank_lag", 16'(if_a.blank), 16'h1);
    cyc();
    chk("hold_disp", if_a.disp_value, 16'hABCD);
    chk("hold_blank", 16'(if_a.blank), 16'h0);
    chk("hold_pulse", 16'(if_a.grant_pulse), 16'h0);
    if_a.req_value = {16'h1234, 16'h5555};
    cyc();
    chk("live_disp", if_a.disp_value, 16'h1234);
    if_a.req_valid = 2'b00;
    cyc();
    chk("drop_grant", 16'(if_a.grant), 16'h0);
    chk("drop_pulse", 16'(if_a.grant_pulse), 16'h0);
    cyc();
    chk("drop_blank", 16'(if_a.blank), 16'h1);
    chk("drop_disp_kept", if_a.disp_value, 16'h1234);

    // Both valid from IDLE: 8 cycles each, rotating.
    if_a.req_value = {16'h1B1B, 16'h0A0A};
    if_a.req_valid = 2'b11;
    cyc();
    chk("rr_pulse0", 16'(if_a.grant_pulse), 16'h1);
    chk("rr_grant0", 16'(if_a.grant), 16'h1);
    for (int i = 2; i <= 8; i++) begin
      cyc();
      chk($sformatf("rr_hold0_c%0d", i), {8'(if_a.grant), 8'(if_a.grant_pulse)}, 16'h0100);
    end
    cyc();
    chk("rr_pulse1", 16'(if_a.grant_pulse), 16'h2);
    chk("rr_grant1", 16'(if_a.grant), 16'h2);
    for (int i = 2; i <= 8; i++) begin
      cyc();
      chk($sformatf("rr_hold1_c%0d", i), {8'(if_a.grant), 8'(if_a.grant_pulse)}, 16'h0200);
    end
    cyc();
    chk("rr_pulse0b", 16'(if_a.grant_pulse), 16'h1);
    chk("rr_grant0b", 16'(if_a.grant), 16'h1);

    // Owner 0 drops at hold_cnt=3 with requester 1 still valid.
    repeat (3) cyc();
    if_a.req_valid = 2'b10;
    cyc();
    chk("odrop_grant", 16'(if_a.grant), 16'h2);
    chk("odrop_pulse", 16'(if_a.grant_pulse), 16'h2);
    if_a.req_valid = 2'b00;
    cyc();
    chk("both_drop_grant", 16'(if_a.grant), 16'h0);
    cyc();
    chk("both_drop_blank", 16'(if_a.blank), 16'h1);
    chk("both_drop_disp", if_a.disp_value, 16'h1B1B);
    cyc();
    chk("both_drop_disp2", if_a.disp_value, 16'h1B1B);

    // Preemption by requester 0 on dut_b.
    if_b.req_value = {16'hBBBB, 16'h0000};
    if_b.req_valid = 2'b10;
    cyc();
    chk("pre_take1", 16'(if_b.grant), 16'h2);
    repeat (2) cyc();
    if_b.req_valid = 2'b11;
    cyc();
    chk("pre_grant0", 16'(if_b.grant), 16'h1);
    chk("pre_pulse0", 16'(if_b.grant_pulse), 16'h1);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      chk($sformatf("pre_stay_c%0d", i), {8'(if_b.grant), 8'(if_b.grant_pulse)}, 16'h0100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seg_sched.md
Name: seg_sched

Overview:
- Time-slicing scheduler that shares the single 4-digit 7-segment display between NUM_REQ requesters, e.g. CPU register view, debug counter and status word.
- Picks an owner by round-robin with minimum hold time and optional priority preemption by requester 0.
- Drives a registered 16-bit value, a blank flag, and a one-cycle scan-advance pulse that the digit-scan block uses as its scan clock enable.

Parameters:
- NUM_REQ, 2: number of requesters, 2..8.
- HOLD_CYCLES, 1024: minimum clock cycles an owner keeps the display before rotation; ≥2.
- SCAN_DIV, 16: clk_in cycles per scan_tick pulse; ≥2.
- PRIO0, 1: 1 = requester 0 preempts any other owner; 0 = pure round-robin.

Ports:
- clk_in, input, 1: single clock.
- rst_in, input, 1: synchronous, active-high reset.
- req_valid, input, NUM_REQ: request to own the display, level-held.
- req_value, input, 16*NUM_REQ: requester i value in bits [16*i+15:16*i].
- grant, output, NUM_REQ: one-hot current owner; all zero when idle.
- grant_pulse, output, NUM_REQ: one-cycle pulse on the cycle ownership is taken.
- disp_value, output, 16: value for the display, registered.
- blank, output, 1: 1 = display must show nothing.
- scan_tick, output, 1: one-cycle digit-advance enable.

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - State becomes IDLE.
  - grant=0, grant_pulse=0, disp_value=16'h0000, blank=1, scan_tick=0.
  - Hold counter, scan divider and RR pointer are cleared; RR pointer = 0.
  - Mid-operation reset aborts the current slice with no pulse.
- scan divider:
  - Free-running modulo-SCAN_DIV counter, independent of state.
  - scan_tick=1 exactly when the counter equals SCAN_DIV-1; first pulse is SCAN_DIV cycles after reset release.
- States:
  - IDLE:
    - Blank=1; grant=0.
    - If any req_valid is set, select the first set bit at or after the RR pointer (wrapping). PRIO0=1 selects index 0 first if set.
    - Go to HOLD next cycle with grant, grant_pulse, hold_cnt=0.
  - HOLD:
    - blank=0; disp_value <= owner's req_value every cycle (1-cycle latency, live tracking); hold_cnt increments, saturating at HOLD_CYCLES-1.
    - Owner drops req_valid: next cycle re-arbitrate as from IDLE, excluding the old owner. If none remain, go to IDLE (blank=1, disp_value keeps its last value).
    - hold_cnt == HOLD_CYCLES-1 and another requester is valid: RR pointer = owner+1 mod NUM_REQ; switch to the next valid requester; hold_cnt=0; grant_pulse on the new owner.
    - hold_cnt saturated and no other requester: stay, no pulse.
    - PRIO0=1, owner≠0 and req_valid[0] rises: preempt next cycle regardless of hold_cnt. Requester 0 is never rotated out by hold expiry while PRIO0=1 and it remains valid.
- Simultaneous owner-drop and hold-expiry: treat as owner-drop.
- Simultaneous expiry and preemption: requester 0 wins.
- Switching cost: exactly one cycle from decision to new grant; grant is never multi-hot and never changes without grant_pulse, except to zero.
- Width: hold_cnt = $clog2(HOLD_CYCLES) bits; RR pointer = $clog2(NUM_REQ) bits, wrapping from NUM_REQ-1 to 0.

Optional Feature:
- Macro: SEG_SCHED_BLINK_EN.
- Defined:
  - Adds input req_blink (NUM_REQ bits) and parameter BLINK_DIV (default 64).
  - While the owner's req_blink bit is 1, blank toggles every BLINK_DIV scan_tick pulses. Blink phase resets to blanked-off (visible) on every ownership change.
  - IDLE forces blank=1.
- Undefined:
  - No req_blink port and no blink counter.
  - blank = (state == IDLE).

Test Plan (NUM_REQ=2, HOLD_CYCLES=8, SCAN_DIV=4, PRIO0=0 unless stated):
- Reset, no requests, 20 cycles → blank=1, grant=00, disp_value=0000; scan_tick on cycles 4, 8, 12, 16, 20 after release.
- req_valid=10, value1=ABCD → grant_pulse=10 one cycle later; disp_value=ABCD and blank=0 the following cycle; change value1 to 1234 → disp_value=1234 one cycle later.
- req_valid=11 held from IDLE → grant 01 for 8 cycles, then 10 for 8, then 01; grant_pulse at each switch.
- PRIO0=1: owner=1 at hold_cnt=2, raise req_valid[0] → grant=01 next cycle; hold 20 cycles with both valid → grant stays 01.
- Owner 0 drops req_valid at hold_cnt=3 with req_valid[1]=1 → grant=10 next cycle. Both drop → IDLE, blank=1, disp_value keeps its last value.
- SEG_SCHED_BLINK_EN, BLINK_DIV=2, owner blink=1 → blank toggles every 8 clk_in cycles; reset asserted mid-blink → blank=1, grant=00 next cycle.
